avl_arbiter: RTL



---
 rtl/configure.sv | 8 +
 rtl/avl_arb_pend.sv | 31 +++
 rtl/avl_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/configure.sv
// configure: state encoding and port indices shared by the avl_arbiter slice
package configure;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/avl_arb_pend.sv
// avl_arb_pend: one-deep request buffer for a single arbiter port
module avl_arb_pend (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        pend,
  output logic [31:0] p_addr,
  output logic [31:0] p_wdata,
  output logic [3:0]  p_wstrb
);
  // capture an accepted request; a grant in the same cycle consumes it directly
  always_ff @(posedge clock) begin
    if (reset) begin
      pend <= 1'b0;
      p_addr <= '0;
      p_wdata <= '0;
      p_wstrb <= '0;
    end else begin
      pend <= clear ? 1'b0 : (load | pend);
      if (load) begin
        p_addr <= addr;
        p_wdata <= wdata;
        p_wstrb <= wstrb;
      end
    end
  end
endmodule

// File: rtl/avl_arbiter.sv
// avl_arbiter: shares the Avalon bridge port between imem and dmem (AVL_ARB_ROUND_ROBIN_EN enables round-robin tie-break)
module avl_arbiter
  import configure::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        avl_valid,
  output logic        avl_instr,
  output logic [31:0] avl_addr,
  output logic [31:0] avl_wdata,
  output logic [3:0]  avl_wstrb,
  input  logic [31:0] avl_rdata,
  input  logic        avl_ready
);
  logic [1:0] state;
  logic i_pend, d_pend, i_acc, d_acc, i_cand, d_cand, open, go, pick_d, sel;
  logic [31:0] i_pa, i_pw, d_pa, d_pw, c_addr, c_wdata;
  logic [3:0] i_ps, d_ps, c_wstrb;
`ifdef AVL_ARB_ROUND_ROBIN_EN
  logic last;
`endif
  avl_arb_pend u_pend_i (
    .clock(clock), .reset(reset), .load(i_acc), .clear(go & ~pick_d),
    .addr(imem_addr), .wdata(32'd0), .wstrb(4'd0),
    .pend(i_pend), .p_addr(i_pa), .p_wdata(i_pw), .p_wstrb(i_ps)
  );
  avl_arb_pend u_pend_d (
    .clock(clock), .reset(reset), .load(d_acc), .clear(go & pick_d),
    .addr(dmem_addr), .wdata(dmem_wdata), .wstrb(dmem_wstrb),
    .pend(d_pend), .p_addr(d_pa), .p_wdata(d_pw), .p_wstrb(d_ps)
  );
  // accept legal requests, form candidates and pick the winner; a port finishing this cycle may re-request
  always_comb begin
    i_acc = imem_valid & ~i_pend & ~(state == BUSY_I & ~avl_ready);
    d_acc = dmem_valid & ~d_pend & ~(state == BUSY_D & ~avl_ready);
    i_cand = i_pend | i_acc;
    d_cand = d_pend | d_acc;
    open = (state == IDLE) | avl_ready;
    go = open & (i_cand | d_cand);
`ifdef AVL_ARB_ROUND_ROBIN_EN
    pick_d = d_cand & (~i_cand | last == PORT_I);
`else
    pick_d = d_cand;
`endif
    sel = pick_d ? PORT_D : PORT_I;
    c_addr = pick_d ? (d_pend ? d_pa : dmem_addr) : (i_pend ? i_pa : imem_addr);
    c_wdata = pick_d ? (d_pend ? d_pw : dmem_wdata) : (i_pend ? i_pw : 32'd0);
    c_wstrb = pick_d ? (d_pend ? d_ps : dmem_wstrb) : (i_pend ? i_ps : 4'd0);
  end
  // steer the bridge response to the current owner only
  always_comb begin
    imem_ready = state == BUSY_I & avl_ready;
    dmem_ready = state == BUSY_D & avl_ready;
    imem_rdata = state == BUSY_I ? avl_rdata : 32'd0;
    dmem_rdata = state == BUSY_D ? avl_rdata : 32'd0;
  end
  // ownership state and the registered bridge request, held until the next grant
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      avl_valid <= 1'b0;
      avl_instr <= 1'b0;
      avl_addr <= '0;
      avl_wdata <= '0;
      avl_wstrb <= '0;
    end else begin
      avl_valid <= go;
      if (go) begin
        state <= pick_d ? BUSY_D : BUSY_I;
        avl_instr <= sel == PORT_I;
        avl_addr <= c_addr;
        avl_wdata <= c_wdata;
        avl_wstrb <= c_wstrb;
      end else if (open) begin
        state <= IDLE;
      end
    end
  end
`ifdef AVL_ARB_ROUND_ROBIN_EN
  // remember the last granted port so the other one wins the next tie
  always_ff @(posedge clock) begin
    if (reset) last <= PORT_I;
    else if (go) last <= sel;
  end
`endif
endmodule
